// File: rtl/scoreboard.sv
// In-order hazard tracker for a parametrised pipeline depth and read-port count.
// Tracks in-flight register writes per stage after issue, decides whether the
// instruction in D may issue, and registers one forward-source select per port.
module scoreboard #(
    parameter  int NREGS   = 32,
    parameter  int NSTAGES = 3,
    parameter  int NPORTS  = 2,
    localparam int AW      = $clog2(NREGS),
    localparam int SW      = $clog2(NSTAGES + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 issue_valid,
    input  logic                 issue_we,
    input  logic [AW-1:0]        issue_rd,
    input  logic [SW-1:0]        issue_ready_stage,
    input  logic [NPORTS*AW-1:0] issue_rs,
    input  logic [NPORTS-1:0]    issue_rs_used,
    input  logic                 hold,
    input  logic                 flush,
    input  logic [NSTAGES-1:0]   kill_mask,
    output logic                 issue_stall,
    output logic                 issue_fire,
    output logic [NPORTS*SW-1:0] fwd_sel,
    output logic [NREGS-1:0]     pending
);

    // Entry 0 = E, entry NSTAGES-1 = W.
    logic [NSTAGES-1:0]          valid_q, valid_d;
    logic [NSTAGES-1:0][AW-1:0]  rd_q,    rd_d;
    logic [NSTAGES-1:0][SW-1:0]  rdy_q,   rdy_d;
    logic [NPORTS-1:0][SW-1:0]   fwd_q,   fwd_d;

    logic [NPORTS-1:0][SW-1:0]   fwd_sel_c;
    logic [NPORTS-1:0]           hazard;
    logic [SW-1:0]               rdy_in;

    logic                        found;
    int unsigned                 m;
    logic [SW-1:0]               mrdy;
    logic [AW-1:0]               rs;

    // Clamp the incoming ready stage into 1..NSTAGES-1.
    always_comb begin
        if (issue_ready_stage == '0)
            rdy_in = SW'(1);
        else if (int'(issue_ready_stage) > NSTAGES - 1)
            rdy_in = SW'(NSTAGES - 1);
        else
            rdy_in = issue_ready_stage;
    end

    // Per port: find the youngest in-flight writer and derive hazard and forward source.
    always_comb begin
        hazard    = '0;
        fwd_sel_c = '0;
        found     = 1'b0;
        m         = 0;
        mrdy      = '0;
        rs        = '0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            found = 1'b0;
            m     = 0;
            mrdy  = '0;
            rs    = issue_rs[p*AW +: AW];
            for (int unsigned i = 0; i < NSTAGES; i++) begin
                if (!found && valid_q[i] && (rd_q[i] == rs)) begin
                    found = 1'b1;
                    m     = i;
                    mrdy  = rdy_q[i];
                end
            end
            // The consumer reaches E next cycle, when the producer sits at entry m+1.
            if (issue_rs_used[p] && (rs != '0) && found) begin
                hazard[p] = (m + 1) < 32'(mrdy);
                if ((m + 1) <= NSTAGES - 1)
                    fwd_sel_c[p] = SW'(m + 1);
            end
        end
    end

    assign issue_stall = issue_valid & (|hazard);
    assign issue_fire  = issue_valid & ~issue_stall & ~hold & ~flush;
    assign fwd_sel     = fwd_q;

    // Next state: shift entries unless held; kill_mask then clears the new valid bits.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        rdy_d   = rdy_q;
        fwd_d   = fwd_q;
        if (!hold) begin
            for (int unsigned i = 1; i < NSTAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                rd_d[i]    = rd_q[i-1];
                rdy_d[i]   = rdy_q[i-1];
            end
            valid_d[0] = issue_fire & issue_we & (issue_rd != '0);
            rd_d[0]    = issue_rd;
            rdy_d[0]   = rdy_in;
            fwd_d      = issue_fire ? fwd_sel_c : '0;
        end
        valid_d = valid_d & ~kill_mask;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            rd_q    <= '0;
            rdy_q   <= '0;
            fwd_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            rdy_q   <= rdy_d;
            fwd_q   <= fwd_d;
        end
    end

    // Pending-write mask; register 0 is never reported.
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < NSTAGES; i++) begin
            if (valid_q[i])
                pending[rd_q[i]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

endmodule
